// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_unit_pkg : fetch-stage states, bubble word, reset PC         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] C_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg : IF/ID pipeline register with hold, bubble and load        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module if_id_reg
    import pc_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic        hold_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q, pc_plus4_q, instr_q;
    logic        valid_q;

    // Hold wins over bubble so a stalled busy-wait keeps the ID instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0004;
            instr_q    <= C_NOP_INSTR;
            valid_q    <= 1'b0;
        end else if (hold_i) begin
            pc_q       <= pc_q;
        end else if (bubble_i) begin
            instr_q    <= C_NOP_INSTR;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4_i;
            instr_q    <= instr_i;
            valid_q    <= 1'b1;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign instr_o    = instr_q;
    assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_fetch_unit : PC, instruction-memory read port, redirect and drain  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_sel_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    input  logic        imem_busywait_i,
    input  logic [31:0] imem_readdata_i,
    output logic        imem_read_o,
    output logic [31:0] imem_address_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        flush_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  hold_addr_q, hold_addr_d;
    logic         ifid_load, ifid_bubble, ifid_hold;
    logic [31:0]  w_pc_plus4;

    assign w_pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        hold_addr_d    = hold_addr_q;
        imem_read_o    = 1'b0;
        imem_address_o = pc_q;
        ifid_load      = 1'b0;
        ifid_bubble    = 1'b0;
        ifid_hold      = 1'b1;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_read_o = 1'b1;
                ifid_hold   = 1'b0;
                if (pc_sel_i) begin
                    pc_d        = word_align(branch_target_i);
                    ifid_bubble = 1'b1;
                    if (imem_busywait_i) begin
                        state_d     = ST_DRAIN;
                        hold_addr_d = pc_q;
                    end
                end else if (imem_busywait_i) begin
                    ifid_hold   = stall_i;
                    ifid_bubble = !stall_i;
                end else if (stall_i) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    pc_d      = w_pc_plus4;
                end
            end
            ST_DRAIN: begin
                // Keep the in-flight address stable; its data is never used.
                imem_read_o    = 1'b1;
                imem_address_o = hold_addr_q;
                ifid_hold      = 1'b0;
                ifid_bubble    = 1'b1;
                if (pc_sel_i) begin
                    pc_d = word_align(branch_target_i);
                end else if (!imem_busywait_i) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign flush_o = pc_sel_i && ((state_q == ST_FETCH) || (state_q == ST_DRAIN));

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .hold_i     (ifid_hold),
        .pc_i       (pc_q),
        .pc_plus4_i (w_pc_plus4),
        .instr_i    (imem_readdata_i),
        .pc_o       (ifid_pc_o),
        .pc_plus4_o (ifid_pc_plus4_o),
        .instr_o    (ifid_instr_o),
        .valid_o    (ifid_valid_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pc_fetch_unit : directed self-checking bench for pc_fetch_unit     |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pc_sel = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        stall = 1'b0;
    logic        busy = 1'b0;
    logic [31:0] readdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        ifid_valid;
    logic        flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Memory model: each word is its address scrambled with a constant.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign readdata = mem_word(imem_address);

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_sel_i        (pc_sel),
        .branch_target_i (branch_target),
        .stall_i         (stall),
        .imem_busywait_i (busy),
        .imem_readdata_i (readdata),
        .imem_read_o     (imem_read),
        .imem_address_o  (imem_address),
        .ifid_pc_o       (ifid_pc),
        .ifid_pc_plus4_o (ifid_pc_plus4),
        .ifid_instr_o    (ifid_instr),
        .ifid_valid_o    (ifid_valid),
        .flush_o         (flush)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ends in BOOT, half a cycle before the edge that enters FETCH.
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; pc_sel = 1'b0; stall = 1'b0; busy = 1'b0;
        branch_target = 32'h0;
        #3;
        rst_n = 1'b1;
    endtask

    // Leaves the DUT in FETCH with imem_address == a (zero-wait stream).
    task automatic start_at(input logic [31:0] a);
        apply_reset();
        tick(1 + int'(a >> 2));
    endtask

    task automatic test_reset();
        start_at(32'h8);
        pc_sel = 1'b1; branch_target = 32'h40;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (ifid_instr !== 32'h13) begin n_fail++; $display("FAIL reset_instr got %h want %h", ifid_instr, 32'h13); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
        n_checks++; if (imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b want 0", imem_read); end
        n_checks++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc got %h/%h want 0/4", ifid_pc, ifid_pc_plus4); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_read !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL boot_read_flush got %b/%b want 0/0", imem_read, flush); end
        tick(1);
        pc_sel = 1'b0;
        n_checks++; if (imem_read !== 1'b1 || imem_address !== 32'h0) begin n_fail++; $display("FAIL boot_ignores_pcsel got %b/%h want 1/0", imem_read, imem_address); end
        tick(1);
        n_checks++; if (imem_address !== 32'h4) begin n_fail++; $display("FAIL stream_addr4 got %h want 4", imem_address); end
        n_checks++; if (ifid_pc !== 32'h0 || ifid_instr !== mem_word(32'h0) || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch got %h/%h/%b want 0/%h/1", ifid_pc, ifid_instr, ifid_valid, mem_word(32'h0)); end
        tick(1);
        n_checks++; if (imem_address !== 32'h8 || ifid_pc !== 32'h4) begin n_fail++; $display("FAIL stream_addr8 got %h/%h want 8/4", imem_address, ifid_pc); end
    endtask

    task automatic test_busywait();
        start_at(32'h10);
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_checks++; if (imem_address !== 32'h10 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL busy_hold_%0d got %h/%b want 10/0", i, imem_address, ifid_valid); end
        end
        busy = 1'b0;
        tick(1);
        n_checks++; if (ifid_pc !== 32'h10 || ifid_pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL busy_release_pc got %h/%h want 10/14", ifid_pc, ifid_pc_plus4); end
        n_checks++; if (ifid_instr !== mem_word(32'h10) || ifid_valid !== 1'b1 || imem_address !== 32'h14) begin n_fail++; $display("FAIL busy_release_instr got %h/%b/%h want %h/1/14", ifid_instr, ifid_valid, imem_address, mem_word(32'h10)); end
    endtask

    task automatic test_stall();
        start_at(32'hC);
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            n_checks++; if (ifid_pc !== 32'h8 || imem_address !== 32'hC || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_%0d got %h/%h/%b want 8/c/1", i, ifid_pc, imem_address, ifid_valid); end
        end
        stall = 1'b0;
        tick(1);
        n_checks++; if (ifid_pc !== 32'hC || ifid_instr !== mem_word(32'hC)) begin n_fail++; $display("FAIL stall_resume_c got %h/%h want c/%h", ifid_pc, ifid_instr, mem_word(32'hC)); end
        tick(1);
        n_checks++; if (ifid_pc !== 32'h10 || ifid_instr !== mem_word(32'h10)) begin n_fail++; $display("FAIL stall_resume_10 got %h/%h want 10/%h", ifid_pc, ifid_instr, mem_word(32'h10)); end
    endtask

    task automatic test_busy_stall();
        start_at(32'hC);
        busy = 1'b1; stall = 1'b1;
        tick(1);
        n_checks++; if (ifid_pc !== 32'h8 || ifid_valid !== 1'b1 || imem_address !== 32'hC) begin n_fail++; $display("FAIL busy_stall_hold got %h/%b/%h want 8/1/c", ifid_pc, ifid_valid, imem_address); end
        busy = 1'b0; stall = 1'b0;
    endtask

    task automatic test_redirect();
        start_at(32'h20);
        pc_sel = 1'b1; branch_target = 32'h100; stall = 1'b1;
        #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL redirect_flush got %b want 1", flush); end
        tick(1);
        pc_sel = 1'b0; stall = 1'b0;
        #1;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || imem_address !== 32'h100) begin n_fail++; $display("FAIL redirect_bubble got %b/%h/%h want 0/13/100", ifid_valid, ifid_instr, imem_address); end
        n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL redirect_flush_low got %b want 0", flush); end
        tick(1);
        n_checks++; if (ifid_pc !== 32'h100 || ifid_instr !== mem_word(32'h100) || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_target got %h/%h/%b want 100/%h/1", ifid_pc, ifid_instr, ifid_valid, mem_word(32'h100)); end
    endtask

    task automatic test_drain();
        start_at(32'h40);
        busy = 1'b1; pc_sel = 1'b1; branch_target = 32'h200;
        #1;
        n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL drain_flush1 got %b want 1", flush); end
        tick(1);
        pc_sel = 1'b0;
        n_checks++; if (imem_address !== 32'h40 || imem_read !== 1'b1 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL drain_hold_addr got %h/%b/%b want 40/1/0", imem_address, imem_read, ifid_valid); end
        tick(1);
        pc_sel = 1'b1; branch_target = 32'h300;
        #1;
        n_checks++; if (flush !== 1'b1 || imem_address !== 32'h40) begin n_fail++; $display("FAIL drain_flush2 got %b/%h want 1/40", flush, imem_address); end
        tick(1);
        pc_sel = 1'b0; busy = 1'b0;
        n_checks++; if (imem_address !== 32'h40 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL drain_still got %h/%b want 40/0", imem_address, ifid_valid); end
        tick(1);
        n_checks++; if (imem_address !== 32'h300 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL drain_exit got %h/%b want 300/0", imem_address, ifid_valid); end
        tick(1);
        n_checks++; if (ifid_pc !== 32'h300 || ifid_instr !== mem_word(32'h300) || imem_address !== 32'h304) begin n_fail++; $display("FAIL drain_fetch300 got %h/%h/%h want 300/%h/304", ifid_pc, ifid_instr, imem_address, mem_word(32'h300)); end
        busy = 1'b1; pc_sel = 1'b1; branch_target = 32'h200;
        tick(1);
        busy = 1'b0; pc_sel = 1'b0;
        n_checks++; if (imem_address !== 32'h304) begin n_fail++; $display("FAIL drain2_hold got %h want 304", imem_address); end
        tick(1);
        n_checks++; if (imem_address !== 32'h200 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL drain2_exit got %h/%b want 200/0", imem_address, ifid_valid); end
        tick(1);
        n_checks++; if (ifid_pc !== 32'h200 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL drain2_fetch got %h/%b want 200/1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_reset_in_drain();
        start_at(32'h40);
        busy = 1'b1; pc_sel = 1'b1; branch_target = 32'h200;
        tick(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_read !== 1'b0 || flush !== 1'b0 || ifid_instr !== 32'h13) begin n_fail++; $display("FAIL drain_reset got %b/%b/%h want 0/0/13", imem_read, flush, ifid_instr); end
        @(negedge clk);
        rst_n = 1'b1; busy = 1'b0; pc_sel = 1'b0;
        tick(1);
        n_checks++; if (imem_address !== 32'h0 || imem_read !== 1'b1) begin n_fail++; $display("FAIL drain_reset_restart got %h/%b want 0/1", imem_address, imem_read); end
    endtask

    task automatic test_align_wrap();
        start_at(32'h8);
        pc_sel = 1'b1; branch_target = 32'h1003;
        tick(1);
        n_checks++; if (imem_address !== 32'h1000) begin n_fail++; $display("FAIL align got %h want 1000", imem_address); end
        branch_target = 32'hFFFF_FFFF;
        tick(1);
        pc_sel = 1'b0;
        n_checks++; if (imem_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL align_top got %h want fffffffc", imem_address); end
        tick(1);
        n_checks++; if (imem_address !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", imem_address, ifid_pc, ifid_pc_plus4); end
    endtask

    initial begin
        test_reset();
        test_busywait();
        test_stall();
        test_busy_stall();
        test_redirect();
        test_drain();
        test_reset_in_drain();
        test_align_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
